// File: rtl/noise_gate_pkg.sv
// Shared types and helpers for the noise gate: state encoding, full-scale
// gain and a saturating magnitude function.
package noise_gate_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    // Unity gain for a given number of fraction bits.
    function automatic int unsigned gain_full(input int unsigned gain_bits);
        return 32'd1 << gain_bits;
    endfunction

    // |x| for a sign-extended sample of the given width. The most-negative
    // sample has no positive twin, so it saturates to the largest positive value.
    function automatic logic [63:0] abs_sat(input logic signed [63:0] x,
                                            input int unsigned width);
        logic signed [63:0] min_v;
        logic [63:0]        result;
        min_v = -(64'sd1 <<< (width - 1));
        if (x == min_v) begin
            result = (64'd1 << (width - 1)) - 64'd1;
        end else if (x < 0) begin
            result = -x;
        end else begin
            result = x;
        end
        return result;
    endfunction

endpackage

// File: rtl/gate_gain_mult.sv
// Registered gain stage: data_out = (data_in * gain) >>> GAIN_BITS, with a
// one-cycle valid pipeline. data_out keeps its last value when no sample arrives.
module gate_gain_mult #(
    parameter int DATA_LENGTH = 32,
    parameter int GAIN_BITS   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [DATA_LENGTH-1:0] data_in,
    input  logic        [GAIN_BITS:0]     gain,
    output logic                          out_valid,
    output logic signed [DATA_LENGTH-1:0] data_out
);

    // Wide enough that the full signed x unsigned product never overflows.
    localparam int PW = DATA_LENGTH + GAIN_BITS + 2;

    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod;

    assign data_ext = PW'(data_in);
    assign gain_ext = signed'(PW'(gain));
    assign prod     = data_ext * gain_ext;

    // Register the scaled sample; the arithmetic shift floors toward -inf.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= DATA_LENGTH'(prod >>> GAIN_BITS);
            end
        end
    end

endmodule

// File: rtl/noise_gate.sv
// Noise gate: silences samples below a close level and ramps gain through
// attack / hold / release so that opening and closing are click-free.
//
// Handshake: in_valid is a one-cycle strobe with no backpressure; a sample is
// accepted on every cycle in_valid is high, and out_valid follows it exactly
// one cycle later with data_out registered alongside.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int          DATA_LENGTH  = 32,
    parameter int          GAIN_BITS    = 8,
    parameter int unsigned ATTACK_STEP  = 64,
    parameter int unsigned RELEASE_STEP = 64,
    parameter int unsigned HOLD_SAMPLES = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [DATA_LENGTH-1:0] data_in,
    input  logic        [DATA_LENGTH-1:0] threshold,
    input  logic        [DATA_LENGTH-1:0] hysteresis,
    output logic                          out_valid,
    output logic signed [DATA_LENGTH-1:0] data_out,
    output logic                          gate_open,
    output gate_state_t                   state_dbg
);

    localparam int          GW = GAIN_BITS + 1;
    localparam int unsigned GF = gain_full(GAIN_BITS);
    localparam int          CW = $clog2(HOLD_SAMPLES + 1);

    gate_state_t    state_q, state_d;
    logic [GW-1:0]  gain_q, gain_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [63:0]            mag;
    logic [DATA_LENGTH-1:0] close_level;
    logic                   loud;
    logic                   quiet;
    logic [31:0]            gain_up;
    logic                   attack_done;
    logic                   release_done;

    assign mag          = abs_sat(64'(data_in), DATA_LENGTH);
    assign close_level  = (threshold > hysteresis) ? (threshold - hysteresis) : '0;
    assign loud         = mag > 64'(threshold);
    assign quiet        = mag < 64'(close_level);
    assign gain_up      = 32'(gain_q) + 32'(ATTACK_STEP);
    assign attack_done  = gain_up >= 32'(GF);
    assign release_done = 32'(gain_q) <= 32'(RELEASE_STEP);

    // State, gain and hold counter registers; frozen unless a sample arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLOSED;
            gain_q    <= '0;
            cnt_q     <= '0;
            gate_open <= 1'b0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            cnt_q     <= cnt_d;
            gate_open <= (state_d != CLOSED);
        end
    end

    // Next-state and gain ramp for the current valid sample.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            unique case (state_q)
                CLOSED: begin
                    if (loud) begin
                        if (attack_done) begin
                            state_d = OPEN;
                            gain_d  = GW'(GF);
                        end else begin
                            state_d = ATTACK;
                            gain_d  = GW'(gain_up);
                        end
                    end
                end
                ATTACK: begin
                    if (attack_done) begin
                        state_d = OPEN;
                        gain_d  = GW'(GF);
                    end else begin
                        gain_d  = GW'(gain_up);
                    end
                end
                OPEN: begin
                    if (quiet) begin
                        state_d = HOLD;
                        cnt_d   = CW'(HOLD_SAMPLES);
                    end
                end
                HOLD: begin
                    if (!quiet) begin
                        state_d = OPEN;
                    end else if (cnt_q == CW'(1)) begin
                        state_d = RELEASE;
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                    end
                end
                RELEASE: begin
                    if (loud) begin
                        if (attack_done) begin
                            state_d = OPEN;
                            gain_d  = GW'(GF);
                        end else begin
                            state_d = ATTACK;
                            gain_d  = GW'(gain_up);
                        end
                    end else if (release_done) begin
                        state_d = CLOSED;
                        gain_d  = '0;
                    end else begin
                        gain_d  = gain_q - GW'(RELEASE_STEP);
                    end
                end
                default: begin
                    state_d = CLOSED;
                    gain_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign state_dbg = state_q;

    // The multiplier sees the gain before this sample's update.
    gate_gain_mult #(
        .DATA_LENGTH (DATA_LENGTH),
        .GAIN_BITS   (GAIN_BITS)
    ) u_mult (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .gain      (gain_q),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

endmodule

// File: tb/tb_noise_gate.sv
// Bench for noise_gate: directed scenarios plus randomized traffic, checked
// against a sample-level model of the gate's gain rules.
module tb_noise_gate;
    import noise_gate_pkg::*;

    localparam int GFULL = 256;
    localparam int ATK   = 64;
    localparam int REL   = 64;
    localparam int HOLDN = 4;

    localparam int M_CLOSED  = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_OPEN    = 2;
    localparam int M_HOLD    = 3;
    localparam int M_RELEASE = 4;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [31:0] data_in;
    logic        [31:0] threshold;
    logic        [31:0] hysteresis;
    logic               out_valid;
    logic signed [31:0] data_out;
    logic               gate_open;
    gate_state_t        state_dbg;

    always #5 clk = ~clk;

    noise_gate #(
        .DATA_LENGTH  (32),
        .GAIN_BITS    (8),
        .ATTACK_STEP  (ATK),
        .RELEASE_STEP (REL),
        .HOLD_SAMPLES (HOLDN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .threshold  (threshold),
        .hysteresis (hysteresis),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .gate_open  (gate_open),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic        exp_valid;
    logic        exp_open;

    int          m_mode;
    int          m_gain;
    int          m_cnt;
    logic [31:0] m_last;

    function automatic void model_reset();
        m_mode = M_CLOSED;
        m_gain = 0;
        m_cnt  = 0;
        m_last = '0;
        exp_q.delete();
    endfunction

    function automatic void model_open_more();
        if (m_gain + ATK >= GFULL) begin
            m_gain = GFULL;
            m_mode = M_OPEN;
        end else begin
            m_gain = m_gain + ATK;
            m_mode = M_ATTACK;
        end
    endfunction

    // One accepted sample: output from the old gain, then the gain rules.
    function automatic void model_sample(input logic signed [31:0] d);
        longint mag, thr, cls, prod, q;
        bit     loud, quiet;
        if (d == 32'sh8000_0000) mag = 64'd2147483647;
        else if (d < 0)          mag = -longint'(d);
        else                     mag = longint'(d);
        thr   = longint'({32'd0, threshold});
        cls   = (threshold > hysteresis) ? longint'({32'd0, threshold - hysteresis}) : 0;
        loud  = mag > thr;
        quiet = mag < cls;
        prod  = longint'(d) * longint'(m_gain);
        q     = prod / GFULL;
        if (prod < 0 && (prod % GFULL) != 0) q = q - 1;
        m_last = q[31:0];
        case (m_mode)
            M_CLOSED:  if (loud) model_open_more();
            M_ATTACK:  model_open_more();
            M_OPEN:    if (quiet) begin m_mode = M_HOLD; m_cnt = HOLDN; end
            M_HOLD: begin
                if (!quiet)          m_mode = M_OPEN;
                else if (m_cnt == 1) m_mode = M_RELEASE;
                else                 m_cnt  = m_cnt - 1;
            end
            default: begin
                if (loud) model_open_more();
                else if (m_gain - REL <= 0) begin m_gain = 0; m_mode = M_CLOSED; end
                else m_gain = m_gain - REL;
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic signed [31:0] d);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
        if (v) model_sample(d);
        exp_q.push_back(m_last);
        exp_valid = v;
        exp_open  = (m_mode != M_CLOSED);
    endtask

    task automatic hold_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        data_in  = 32'sd2000;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] e;
        threshold  = 32'd1000;
        hysteresis = 32'd200;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        data_in  = 32'sd2000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || data_out !== 32'sd0 || gate_open !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_init[%0d]: got v=%b d=%0d open=%b expected 0/0/0",
                         i, out_valid, data_out, gate_open);
            end
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        // Open the gate so the next reset has something to clear.
        for (int i = 0; i < 6; i++) drive(1'b1, 32'sd2000);
        exp_q.delete();
        n_checks++;
        if (data_out !== 32'sd2000 || gate_open !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_preopen: got d=%0d open=%b expected 2000/1", data_out, gate_open);
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || data_out !== 32'sd0 || gate_open !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_clear[%0d]: got v=%b d=%0d open=%b expected 0/0/0",
                         i, out_valid, data_out, gate_open);
            end
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        e = '0;
        drive(1'b1, 32'sd2000);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== 32'sd0 || data_out !== e) begin
            n_errors++;
            $display("FAIL reset_first: got %0d expected 0", data_out);
        end
        hold_reset(1);
    endtask

    task automatic test_quiet();
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'sd500);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || data_out !== 32'sd0 || data_out !== e || gate_open !== 1'b0) begin
                n_errors++;
                $display("FAIL quiet[%0d]: got v=%b d=%0d open=%b expected 1/0/0",
                         i, out_valid, data_out, gate_open);
            end
        end
    endtask

    task automatic test_open();
        logic [31:0] e;
        logic signed [31:0] want [6];
        want = '{32'sd0, 32'sd500, 32'sd1000, 32'sd1500, 32'sd2000, 32'sd2000};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'sd2000);
            e = exp_q.pop_front();
            n_checks++;
            if (data_out !== want[i] || data_out !== e || gate_open !== 1'b1) begin
                n_errors++;
                $display("FAIL open_ramp[%0d]: got d=%0d open=%b expected %0d/1",
                         i, data_out, gate_open, want[i]);
            end
            if (i == 3) begin
                n_checks++;
                if (state_dbg !== OPEN) begin
                    n_errors++;
                    $display("FAIL open_state: got %0d expected %0d", state_dbg, OPEN);
                end
            end
        end
    endtask

    task automatic test_release();
        logic [31:0] e;
        drive(1'b1, -32'sd900);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== -32'sd900 || data_out !== e || state_dbg !== OPEN) begin
            n_errors++;
            $display("FAIL release_notquiet: got d=%0d st=%0d expected -900/%0d",
                     data_out, state_dbg, OPEN);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'sd100);
            e = exp_q.pop_front();
            n_checks++;
            if (data_out !== e || gate_open !== exp_open) begin
                n_errors++;
                $display("FAIL release_ramp[%0d]: got d=%0d open=%b expected %0d/%b",
                         i, data_out, gate_open, $signed(e), exp_open);
            end
        end
        n_checks++;
        if (state_dbg !== CLOSED || data_out !== 32'sd0) begin
            n_errors++;
            $display("FAIL release_closed: got st=%0d d=%0d expected %0d/0", state_dbg, data_out, CLOSED);
        end
    endtask

    task automatic test_retrigger();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'sd2000);
        for (int i = 0; i < 7; i++) drive(1'b1, 32'sd100);
        exp_q.delete();
        n_checks++;
        if (state_dbg !== RELEASE || m_gain != 128) begin
            n_errors++;
            $display("FAIL retrig_setup: got st=%0d expected %0d (model gain %0d)", state_dbg, RELEASE, m_gain);
        end
        drive(1'b1, -32'sd3);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== -32'sd2 || data_out !== e) begin
            n_errors++;
            $display("FAIL retrig_floor: got %0d expected -2", data_out);
        end
        drive(1'b1, 32'sd2000);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e || state_dbg !== ATTACK || gate_open !== 1'b1) begin
            n_errors++;
            $display("FAIL retrig_attack: got d=%0d st=%0d expected %0d/%0d",
                     data_out, state_dbg, $signed(e), ATTACK);
        end
    endtask

    task automatic test_edge();
        logic [31:0] e;
        hold_reset(1);
        drive(1'b1, 32'sd2000);
        drive(1'b1, 32'sd2000);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'sd7777);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b0 || data_out !== 32'sd500 || data_out !== e || state_dbg !== ATTACK) begin
                n_errors++;
                $display("FAIL idle_freeze[%0d]: got v=%b d=%0d st=%0d expected 0/500/%0d",
                         i, out_valid, data_out, state_dbg, ATTACK);
            end
        end
        drive(1'b1, 32'sd2000);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== 32'sd1000 || data_out !== e) begin
            n_errors++;
            $display("FAIL idle_resume: got %0d expected 1000", data_out);
        end
        hold_reset(1);
        drive(1'b1, 32'sh8000_0000);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== 32'sd0 || data_out !== e || state_dbg !== ATTACK || gate_open !== 1'b1) begin
            n_errors++;
            $display("FAIL most_negative: got d=%0d st=%0d open=%b expected 0/%0d/1",
                     data_out, state_dbg, gate_open, ATTACK);
        end
        drive(1'b1, 32'sd2000);
        hold_reset(1);
        drive(1'b1, 32'sd2000);
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== 32'sd0 || data_out !== e || state_dbg !== ATTACK) begin
            n_errors++;
            $display("FAIL reset_mid_attack: got d=%0d st=%0d expected 0/%0d", data_out, state_dbg, ATTACK);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]        e;
        logic signed [31:0] d;
        logic               v;
        hold_reset(1);
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                threshold  = $urandom_range(0, 3000);
                hysteresis = $urandom_range(0, 1500);
            end
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) d = 32'sh8000_0000;
            else begin
                d = $urandom_range(0, 3500);
                if ($urandom_range(0, 1) == 1) d = -d;
            end
            drive(v, d);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== exp_valid || data_out !== e || gate_open !== exp_open) begin
                n_errors++;
                $display("FAIL random[%0d]: got v=%b d=%0d open=%b expected %b/%0d/%b",
                         i, out_valid, data_out, gate_open, exp_valid, $signed(e), exp_open);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        data_in    = '0;
        threshold  = 32'd1000;
        hysteresis = 32'd200;
        model_reset();
        test_reset();
        test_quiet();
        test_open();
        test_release();
        test_retrigger();
        test_edge();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
